mem_bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter and sequencer for the shared data bus: Memory_Controller address decode, RAM, UART and GPIO.
- Master 0 (m0) is the core MEM-stage data port. Master 1 (m1) is the debug/program-loader port.
- Grants the bus round-robin, holds the grant for one complete transfer, returns registered read data and acknowledges.
- Drives core_stall so the hazard logic holds the pipeline while a core access is outstanding.

---
 rtl/mem_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master, one-slave data-bus arbiter and transfer sequencer.
// m0 is the core MEM-stage port and m1 is the debug/loader port. Each granted
// transfer runs IDLE -> BUSY -> DONE. Contention is resolved round-robin.
// A missing bus_ready is aborted after TIMEOUT cycles and reported through err.
module mem_bus_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_err,
  output logic                  bus_re,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_ready,
  output logic                  core_stall,
  output logic                  grant,
  output logic                  busy
);

  // The counter only has to reach TIMEOUT-1. With TIMEOUT=0 it just saturates.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t                  state;
  logic                    rr_last;
  logic                    we_lat;
  logic [CW-1:0]           cnt;

  logic                    any_req;
  logic                    pick;
  logic                    pick_we;
  logic [ADDR_WIDTH-1:0]   pick_addr;
  logic [DATA_WIDTH-1:0]   pick_wdata;
  logic                    timeout_hit;
  logic                    finish;
  logic [DATA_WIDTH-1:0]   cap_rdata;
  logic                    cap_err;

  // Choose the winner and its command, and decide how a BUSY cycle completes.
  always_comb begin
    any_req     = m0_req | m1_req;
    pick        = (m0_req & m1_req) ? ~rr_last : m1_req;
    pick_we     = pick ? m1_we : m0_we;
    pick_addr   = pick ? m1_addr : m0_addr;
    pick_wdata  = pick ? m1_wdata : m0_wdata;
    timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);
    finish      = bus_ready | timeout_hit;
    cap_rdata   = (bus_ready & ~we_lat) ? bus_rdata : '0;
    cap_err     = ~bus_ready;
  end

  // The core is held until its ack appears, so the pipeline advances on that edge.
  assign core_stall = m0_req & ~m0_ack;

  // Transfer sequencer. All bus-side and master-side outputs are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rr_last   <= 1'b1;
      we_lat    <= 1'b0;
      cnt       <= '0;
      grant     <= 1'b0;
      busy      <= 1'b0;
      bus_re    <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      m0_ack    <= 1'b0;
      m0_rdata  <= '0;
      m0_err    <= 1'b0;
      m1_ack    <= 1'b0;
      m1_rdata  <= '0;
      m1_err    <= 1'b0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant     <= pick;
            rr_last   <= pick;
            we_lat    <= pick_we;
            bus_addr  <= pick_addr;
            bus_wdata <= pick_wdata;
            bus_re    <= ~pick_we;
            bus_we    <= pick_we;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (finish) begin
            bus_re <= 1'b0;
            bus_we <= 1'b0;
            state  <= DONE;
            if (grant) begin
              m1_ack   <= 1'b1;
              m1_rdata <= cap_rdata;
              m1_err   <= cap_err;
            end else begin
              m0_ack   <= 1'b1;
              m0_rdata <= cap_rdata;
              m0_err   <= cap_err;
            end
          end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy   <= 1'b0;
          bus_re <= 1'b0;
          bus_we <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter.
// Per-cycle vector table plus hand-written multi-cycle sequences.
// Inputs are driven on the falling edge. Outputs are sampled 1 time unit later.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_we, m0_ack, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_ack, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        bus_re, bus_we, bus_ready;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        core_stall, grant, busy;

  int n_pass  = 0;
  int n_total = 0;

  mem_bus_arbiter #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .TIMEOUT   (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_ack    (m0_ack),
    .m0_rdata  (m0_rdata),
    .m0_err    (m0_err),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_ack    (m1_ack),
    .m1_rdata  (m1_rdata),
    .m1_err    (m1_err),
    .bus_re    (bus_re),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready),
    .core_stall(core_stall),
    .grant     (grant),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        m0_req, m0_we;
    logic [31:0] m0_addr, m0_wdata;
    logic        m1_req, m1_we;
    logic [31:0] m1_addr, m1_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        e_m0_ack;
    logic [31:0] e_m0_rdata;
    logic        e_m0_err;
    logic        e_m1_ack;
    logic [31:0] e_m1_rdata;
    logic        e_m1_err;
    logic        e_re, e_we;
    logic [31:0] e_addr, e_wdata;
    logic        e_stall, e_grant, e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic a0r, input logic a0w, input logic [31:0] a0a, input logic [31:0] a0d,
    input logic a1r, input logic a1w, input logic [31:0] a1a, input logic [31:0] a1d,
    input logic [31:0] brd, input logic brdy,
    input logic x0a, input logic [31:0] x0d, input logic x0e,
    input logic x1a, input logic [31:0] x1d, input logic x1e,
    input logic xre, input logic xwe, input logic [31:0] xad, input logic [31:0] xwd,
    input logic xst, input logic xgr, input logic xbz);
    vec_t v;
    v.m0_req = a0r; v.m0_we = a0w; v.m0_addr = a0a; v.m0_wdata = a0d;
    v.m1_req = a1r; v.m1_we = a1w; v.m1_addr = a1a; v.m1_wdata = a1d;
    v.bus_rdata = brd; v.bus_ready = brdy;
    v.e_m0_ack = x0a; v.e_m0_rdata = x0d; v.e_m0_err = x0e;
    v.e_m1_ack = x1a; v.e_m1_rdata = x1d; v.e_m1_err = x1e;
    v.e_re = xre; v.e_we = xwe; v.e_addr = xad; v.e_wdata = xwd;
    v.e_stall = xst; v.e_grant = xgr; v.e_busy = xbz;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  initial begin
    // Reset with all inputs idle.
    reset = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    bus_rdata = '0; bus_ready = 1'b0;

    // Concurrent requests: m0 reads 0x100, m1 writes 0x12345678 to 0x200. m0 goes first.
    vecs.push_back(mk(1,0,32'h100,0, 1,1,32'h200,32'h12345678, 32'hCAFEF00D,1, 0,0,0, 0,0,0, 0,0,0,0, 1,0,0));
    vecs.push_back(mk(1,0,32'h100,0, 1,1,32'h200,32'h12345678, 32'hCAFEF00D,1, 0,0,0, 0,0,0, 1,0,32'h100,0, 1,0,1));
    vecs.push_back(mk(1,0,32'h100,0, 1,1,32'h200,32'h12345678, 32'hCAFEF00D,1, 1,32'hCAFEF00D,0, 0,0,0, 0,0,32'h100,0, 0,0,1));
    vecs.push_back(mk(0,0,32'h100,0, 1,1,32'h200,32'h12345678, 32'hCAFEF00D,1, 0,32'hCAFEF00D,0, 0,0,0, 0,0,32'h100,0, 0,0,0));
    vecs.push_back(mk(0,0,32'h100,0, 1,1,32'h200,32'h12345678, 32'hCAFEF00D,1, 0,32'hCAFEF00D,0, 0,0,0, 0,1,32'h200,32'h12345678, 0,1,1));
    vecs.push_back(mk(0,0,32'h100,0, 1,1,32'h200,32'h12345678, 32'hCAFEF00D,1, 0,32'hCAFEF00D,0, 1,0,0, 0,0,32'h200,32'h12345678, 0,1,1));
    vecs.push_back(mk(0,0,32'h100,0, 0,1,32'h200,32'h12345678, 32'hCAFEF00D,1, 0,32'hCAFEF00D,0, 0,0,0, 0,0,32'h200,32'h12345678, 0,1,0));
    // Single core read of 0x10010000 returning 0xDEADBEEF.
    vecs.push_back(mk(1,0,32'h10010000,0, 0,0,0,0, 32'hDEADBEEF,1, 0,32'hCAFEF00D,0, 0,0,0, 0,0,32'h200,32'h12345678, 1,1,0));
    vecs.push_back(mk(1,0,32'h10010000,0, 0,0,0,0, 32'hDEADBEEF,1, 0,32'hCAFEF00D,0, 0,0,0, 1,0,32'h10010000,0, 1,0,1));
    vecs.push_back(mk(1,0,32'h10010000,0, 0,0,0,0, 32'hDEADBEEF,1, 1,32'hDEADBEEF,0, 0,0,0, 0,0,32'h10010000,0, 0,0,1));
    vecs.push_back(mk(0,0,32'h10010000,0, 0,0,0,0, 32'hDEADBEEF,1, 0,32'hDEADBEEF,0, 0,0,0, 0,0,32'h10010000,0, 0,0,0));
    // Single debug-port read of 0xF0 returning 0x0BADF00D.
    vecs.push_back(mk(0,0,0,0, 1,0,32'hF0,0, 32'h0BADF00D,1, 0,32'hDEADBEEF,0, 0,0,0, 0,0,32'h10010000,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,0,32'hF0,0, 32'h0BADF00D,1, 0,32'hDEADBEEF,0, 0,0,0, 1,0,32'hF0,0, 0,1,1));
    vecs.push_back(mk(0,0,0,0, 1,0,32'hF0,0, 32'h0BADF00D,1, 0,32'hDEADBEEF,0, 1,32'h0BADF00D,0, 0,0,32'hF0,0, 0,1,1));
    vecs.push_back(mk(0,0,0,0, 0,0,32'hF0,0, 32'h0BADF00D,1, 0,32'hDEADBEEF,0, 0,32'h0BADF00D,0, 0,0,32'hF0,0, 0,1,0));

    @(negedge clk); #1;
    chk("rst.m0_ack", m0_ack, 0);   chk("rst.m0_rdata", m0_rdata, 0); chk("rst.m0_err", m0_err, 0);
    chk("rst.m1_ack", m1_ack, 0);   chk("rst.m1_rdata", m1_rdata, 0); chk("rst.m1_err", m1_err, 0);
    chk("rst.bus_re", bus_re, 0);   chk("rst.bus_we", bus_we, 0);
    chk("rst.bus_addr", bus_addr, 0); chk("rst.bus_wdata", bus_wdata, 0);
    chk("rst.grant", grant, 0);     chk("rst.busy", busy, 0);         chk("rst.core_stall", core_stall, 0);
    @(negedge clk);
    reset = 1'b1;

    // Vector table: drive one vector per cycle and compare every output.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      m0_req = vecs[i].m0_req; m0_we = vecs[i].m0_we; m0_addr = vecs[i].m0_addr; m0_wdata = vecs[i].m0_wdata;
      m1_req = vecs[i].m1_req; m1_we = vecs[i].m1_we; m1_addr = vecs[i].m1_addr; m1_wdata = vecs[i].m1_wdata;
      bus_rdata = vecs[i].bus_rdata; bus_ready = vecs[i].bus_ready;
      #1;
      chk($sformatf("v%0d.m0_ack", i), m0_ack, vecs[i].e_m0_ack);
      chk($sformatf("v%0d.m0_rdata", i), m0_rdata, vecs[i].e_m0_rdata);
      chk($sformatf("v%0d.m0_err", i), m0_err, vecs[i].e_m0_err);
      chk($sformatf("v%0d.m1_ack", i), m1_ack, vecs[i].e_m1_ack);
      chk($sformatf("v%0d.m1_rdata", i), m1_rdata, vecs[i].e_m1_rdata);
      chk($sformatf("v%0d.m1_err", i), m1_err, vecs[i].e_m1_err);
      chk($sformatf("v%0d.bus_re", i), bus_re, vecs[i].e_re);
      chk($sformatf("v%0d.bus_we", i), bus_we, vecs[i].e_we);
      chk($sformatf("v%0d.bus_addr", i), bus_addr, vecs[i].e_addr);
      chk($sformatf("v%0d.bus_wdata", i), bus_wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d.core_stall", i), core_stall, vecs[i].e_stall);
      chk($sformatf("v%0d.grant", i), grant, vecs[i].e_grant);
      chk($sformatf("v%0d.busy", i), busy, vecs[i].e_busy);
    end

    // Slow slave: bus_ready is low for 5 BUSY cycles and high on the 6th.
    @(negedge clk);
    m0_req = 1; m0_we = 0; m0_addr = 32'h20000040; bus_rdata = 32'h5A5A1234; bus_ready = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      bus_ready = (i == 6);
      #1;
      chk($sformatf("slow%0d.busy", i), busy, 1);
      chk($sformatf("slow%0d.bus_re", i), bus_re, 1);
      chk($sformatf("slow%0d.bus_addr", i), bus_addr, 32'h20000040);
      chk($sformatf("slow%0d.m0_ack", i), m0_ack, 0);
    end
    @(negedge clk);
    bus_ready = 0;
    #1;
    chk("slow.ack", m0_ack, 1); chk("slow.err", m0_err, 0); chk("slow.rdata", m0_rdata, 32'h5A5A1234);
    chk("slow.bus_re_done", bus_re, 0);
    @(negedge clk);
    m0_req = 0;
    #1;
    chk("slow.idle_busy", busy, 0); chk("slow.idle_ack", m0_ack, 0);

    // Timeout: bus_ready never rises, so the transfer gets exactly 16 BUSY cycles.
    @(negedge clk);
    m1_req = 1; m1_we = 0; m1_addr = 32'h30000000; bus_rdata = 32'hFFFFFFFF; bus_ready = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk); #1;
      chk($sformatf("to%0d.busy", i), busy, 1);
      chk($sformatf("to%0d.m1_ack", i), m1_ack, 0);
    end
    @(negedge clk); #1;
    chk("to.ack", m1_ack, 1); chk("to.err", m1_err, 1); chk("to.rdata", m1_rdata, 0);
    chk("to.m0_ack", m0_ack, 0); chk("to.bus_re", bus_re, 0);
    @(negedge clk);
    m1_req = 0;
    #1;
    chk("to.idle_busy", busy, 0);
    // The next request is served normally and err is cleared.
    @(negedge clk);
    m1_req = 1; m1_addr = 32'h30000004; bus_rdata = 32'h11112222; bus_ready = 1;
    @(negedge clk); #1;
    chk("post.busy", busy, 1); chk("post.grant", grant, 1); chk("post.addr", bus_addr, 32'h30000004);
    @(negedge clk); #1;
    chk("post.ack", m1_ack, 1); chk("post.err", m1_err, 0); chk("post.rdata", m1_rdata, 32'h11112222);
    @(negedge clk);
    m1_req = 0;
    #1;
    chk("post.idle_busy", busy, 0);

    // Asynchronous reset in the middle of a stalled m0 transfer.
    @(negedge clk);
    m0_req = 1; m0_we = 0; m0_addr = 32'h40000000; bus_ready = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); #1;
      chk($sformatf("mid%0d.busy", i), busy, 1);
    end
    #2;
    reset = 1'b0;
    m0_req = 0;
    #1;
    chk("arst.busy", busy, 0);       chk("arst.bus_re", bus_re, 0);   chk("arst.bus_addr", bus_addr, 0);
    chk("arst.m0_rdata", m0_rdata, 0); chk("arst.m1_rdata", m1_rdata, 0); chk("arst.m0_ack", m0_ack, 0);
    chk("arst.core_stall", core_stall, 0);
    @(negedge clk); #1;
    chk("arst.no_ack0", m0_ack, 0); chk("arst.no_ack1", m1_ack, 0);
    @(negedge clk);
    reset = 1'b1;

    // Both masters request continuously: grants alternate 0,1,0,1,0,1, three cycles each.
    @(negedge clk);
    m0_req = 1; m0_we = 0; m0_addr = 32'h500;
    m1_req = 1; m1_we = 0; m1_addr = 32'h600; bus_ready = 1;
    for (int t = 0; t < 6; t++) begin
      if (t != 0) @(negedge clk);
      bus_rdata = 32'hB0000000 + 32'(t);
      #1;
      chk($sformatf("rr%0d.idle_busy", t), busy, 0);
      @(negedge clk); #1;
      chk($sformatf("rr%0d.grant", t), grant, 32'(t % 2));
      chk($sformatf("rr%0d.busy", t), busy, 1);
      chk($sformatf("rr%0d.addr", t), bus_addr, (t % 2 == 1) ? 32'h600 : 32'h500);
      @(negedge clk); #1;
      chk($sformatf("rr%0d.m0_ack", t), m0_ack, 32'(t % 2 == 0));
      chk($sformatf("rr%0d.m1_ack", t), m1_ack, 32'(t % 2 == 1));
      chk($sformatf("rr%0d.rdata", t), (t % 2 == 1) ? m1_rdata : m0_rdata, 32'hB0000000 + 32'(t));
      chk($sformatf("rr%0d.core_stall", t), core_stall, 32'(t % 2 == 1));
    end
    @(negedge clk);
    m0_req = 0; m1_req = 0;
    @(negedge clk); #1;
    chk("end.busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
